approx_mul_seq: RTL
===================

APPROX_MUL_SEQ -- requirements
Module: approx_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width; even, at least 4.
REQ-002 SHALL have parameter ELIM_COLS, default 1: pair-0 columns 1..ELIM_COLS forced to zero.
REQ-003 SHALL have parameter OR_COLS, default 3: the next OR_COLS pair-0 columns use OR-sum with no carry.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: operands offered.
REQ-007 SHALL have port in_ready, output, 1: operands accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port x, input, WIDTH: multiplier operand.
REQ-009 SHALL have port y, input, WIDTH: multiplicand operand.
REQ-010 SHALL have port approx_en, input, 1: 1 selects approximate mode, 0 selects exact; sampled on accept.
REQ-011 SHALL have port out_valid, output, 1: product available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the product.
REQ-013 SHALL have port p, output, 2*WIDTH: product.
REQ-014 SHALL have port busy, output, 1: high in RUN.

Function
REQ-015 SHALL, for pair k (0..WIDTH/2-1), form row A = y&{WIDTH{x[2k]}} and row B = y&{WIDTH{x[2k+1]}}.
REQ-016 SHALL compress each pair into t[WIDTH:0] and b[WIDTH-2:0]:
- t[0]=A[0].
- For j=1..WIDTH-1: half-adder of A[j] and B[j-1]; sum goes to t[j]; carry goes to b[j-1] for j<WIDTH-1, and to t[WIDTH] for j=WIDTH-1.
- b[WIDTH-2]=B[WIDTH-1].
REQ-017 SHALL compute pair value = (t + (b<<2)) << 2k, unsigned, accumulated into a 2*WIDTH-bit register; accumulation SHALL NOT overflow.
REQ-018 SHALL, when the latched approx_en=1 and k=0:
- force column c to sum 0 and carry 0 for c in 1..ELIM_COLS;
- set sum = A[c]|B[c-1] and carry 0 for c in ELIM_COLS+1..ELIM_COLS+OR_COLS.
All other pairs and columns SHALL be exact.
REQ-019 SHALL give a result equal to x*y exactly when the latched approx_en=0.
REQ-020 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-021 SHALL, in IDLE, drive in_ready=1; on accept it SHALL latch x, y and approx_en, clear the accumulator, set k=0 and enter RUN.
REQ-022 SHALL, in RUN, process one pair per cycle and increment k; after pair WIDTH/2-1 it SHALL enter DONE.
REQ-023 SHALL give a latency of WIDTH/2+1 cycles from the accept edge to out_valid=1.
REQ-024 SHALL, in DONE, drive out_valid=1 and hold p stable until out_ready=1; the cycle after out_ready=1 it SHALL return to IDLE.
REQ-025 SHALL drive in_ready=0 in RUN and DONE; in_valid in those states SHALL be ignored, with no queuing.
REQ-026 SHALL ignore in_valid and operand changes after accept.
REQ-027 SHALL keep p equal to the last product while out_valid=0.
REQ-028 SHALL ensure approximate results never exceed exact results.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously enter IDLE with in_ready=1, out_valid=0, busy=0, p=0, k=0 and the accumulator at 0.
REQ-030 SHALL, on reset in RUN or DONE, abort the operation and emit no output after reset release.
REQ-031 SHALL resume normal operation on the first clk edge after rst_n deasserts.

Structure
REQ-032 SHALL place the state enum and the default parameter constants in package approx_mul_pkg.
REQ-033 SHALL implement the single-pair compressor of REQ-016 to REQ-018 as combinational sub-module approx_mul_ha_row, parameterised by WIDTH, ELIM_COLS, OR_COLS and an approx-enable input.
REQ-034 SHALL contain the state machine, counter, accumulator and handshake in the top level.

Verification
REQ-035 SHALL cover: x=255, y=255, approx_en=0 -> p=65025 after 5 cycles.
REQ-036 SHALL cover: x=255, y=255, approx_en=1 -> p=64993 (error 32).
REQ-037 SHALL cover: x=3, y=3, approx_en=1 -> p=5; the same operands with approx_en=0 -> p=9.
REQ-038 SHALL cover: out_ready held 0 for 10 cycles in DONE -> p and out_valid stable; in_valid pulses ignored; in_ready=0 throughout.
REQ-039 SHALL cover: rst_n low in cycle 2 of RUN -> out_valid=0 and p=0 immediately; the next transaction x=2, y=7 -> p=14.
REQ-040 SHALL cover: random sweep, 10k vectors -> exact mode equals x*y; approx mode is no greater than x*y and matches the model of REQ-016 to REQ-018.

Source files
------------

// File: rtl/approx_mul_pkg.sv
// Shared types and default constants
// for the sequential approximate multiplier.
package approx_mul_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int ELIM_COLS_DEF = 1;
  localparam int OR_COLS_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/approx_mul_ha_row.sv
// One pair of partial-product rows compressed
// by a half-adder row, optionally approximated.
module approx_mul_ha_row
  import approx_mul_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ELIM_COLS = ELIM_COLS_DEF,
  parameter int OR_COLS   = OR_COLS_DEF
) (
  input  logic             xa,
  input  logic             xb,
  input  logic [WIDTH-1:0] y,
  input  logic             approx,
  output logic [WIDTH:0]   t,
  output logic [WIDTH-2:0] b
);

  logic [WIDTH-1:0] row_a;
  logic [WIDTH-1:0] row_b;

  // Half-adder column chain, with low columns
  // dropped or OR-summed in approximate mode.
  always_comb begin
    logic s;
    logic c;
    row_a = y & {WIDTH{xa}};
    row_b = y & {WIDTH{xb}};
    t     = '0;
    b     = '0;
    s     = 1'b0;
    c     = 1'b0;
    t[0]  = row_a[0];
    for (int j = 1; j < WIDTH; j++) begin
      s = row_a[j] ^ row_b[j-1];
      c = row_a[j] & row_b[j-1];
      if (approx && j <= ELIM_COLS) begin
        s = 1'b0;
        c = 1'b0;
      end else if (approx &&
                   j <= ELIM_COLS + OR_COLS) begin
        s = row_a[j] | row_b[j-1];
        c = 1'b0;
      end
      t[j] = s;
      if (j < WIDTH - 1) b[j-1] = c;
      else               t[WIDTH] = c;
    end
    b[WIDTH-2] = row_b[WIDTH-1];
  end

endmodule

// File: rtl/approx_mul_seq.sv
// Radix-4 sequential multiplier, one operand bit
// pair per cycle, with an approximate mode.
module approx_mul_seq
  import approx_mul_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ELIM_COLS = ELIM_COLS_DEF,
  parameter int OR_COLS   = OR_COLS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int NP = WIDTH / 2;
  localparam int KW = $clog2(NP + 1);
  localparam int PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ae_q, ae_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q, p_d;

  logic [WIDTH:0]   t;
  logic [WIDTH-2:0] b;
  logic [PW-1:0]    pv;
  logic             row_approx;

  // Only the first pair is ever approximated.
  assign row_approx = ae_q && (k_q == '0);

  approx_mul_ha_row #(
    .WIDTH     (WIDTH),
    .ELIM_COLS (ELIM_COLS),
    .OR_COLS   (OR_COLS)
  ) u_row (
    .xa     (x_q[0]),
    .xb     (x_q[1]),
    .y      (y_q),
    .approx (row_approx),
    .t      (t),
    .b      (b)
  );

  // Weighted pair value for the current step.
  always_comb begin
    pv = PW'(t) + (PW'(b) << 2);
    pv = pv << {k_q, 1'b0};
  end

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    y_d       = y_q;
    ae_d      = ae_q;
    acc_d     = acc_q;
    p_d       = p_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = x;
          y_d     = y;
          ae_d    = approx_en;
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (k_q == KW'(NP)) begin
          p_d     = acc_q;
          state_d = ST_DONE;
        end else begin
          acc_d = acc_q + pv;
          x_d   = x_q >> 2;
          k_d   = k_q + KW'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign p = p_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ae_q    <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ae_q    <= ae_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

endmodule
